nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand (operand width W = 4*NIBBLES).
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port A  input  W  first operand; captured on the accepted Start.
REQ-006 SHALL have port B  input  W  second operand; captured on the accepted Start.
REQ-007 SHALL have port C_in  input  1  initial carry-in; captured on the accepted Start.
REQ-008 SHALL have port Busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle pulse when Sum and C_out are valid.
REQ-010 SHALL have port Sum  output  W  result; held until the next accepted Start.
REQ-011 SHALL have port C_out  output  1  final carry-out; held with Sum.
REQ-012 SHALL have port Add_X  output  4  operand-X slice driven to the external 4-bit adder.
REQ-013 SHALL have port Add_Y  output  4  operand-Y slice driven to the external 4-bit adder.
REQ-014 SHALL have port Add_Ci  output  1  carry-in driven to the adder.
REQ-015 SHALL have port Add_S  input  4  sum returned by the adder (combinational, same cycle).
REQ-016 SHALL have port Add_Co  input  1  carry returned by the adder (combinational, same cycle).

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE: Busy=0; Start=1 SHALL capture A, B and C_in, clear the slice counter, and move to RUN.
REQ-019 RUN: on each cycle the block SHALL drive Add_X/Add_Y with slice k (bits 4k+3:4k, k=counter), drive Add_Ci with the carry register, write Add_S into Sum slice k, load Add_Co into the carry register, and increment k.
REQ-020 RUN SHALL go to DONE after the slice with k=NIBBLES-1 is processed; C_out SHALL then equal the final Add_Co.
REQ-021 DONE SHALL last exactly one cycle with Done=1 and Busy=0, then return to IDLE.
REQ-022 Latency SHALL be fixed: Done asserts NIBBLES+1 cycles after the edge that accepts Start (5 cycles for the default).
REQ-023 Busy SHALL be 1 in RUN only; Start in RUN or DONE SHALL be ignored and not queued.
REQ-024 In IDLE and DONE, Add_X, Add_Y and Add_Ci SHALL be 0.
REQ-025 Captured operands SHALL be unaffected by changes on A, B and C_in after acceptance.
REQ-026 Sum wraps modulo 2^W; overflow SHALL be reported only through C_out.

Reset
REQ-027 Rst_n=0 SHALL immediately force IDLE, with Busy=0, Done=0, Sum=0, C_out=0, counter=0, carry register=0, and all Add_* outputs 0.
REQ-028 Reset asserted during RUN SHALL abort the operation with no Done pulse; the first Start after release SHALL be accepted normally.

Configuration
REQ-029 With macro NIBBLE_ADD_SUB_EN defined, the block SHALL have an extra input Sub (1 bit), captured with Start. When Sub=1, B SHALL be inverted on capture and the initial carry SHALL be forced to 1, ignoring C_in, so that Sum = A-B mod 2^W and C_out=1 means no borrow.
REQ-030 Without NIBBLE_ADD_SUB_EN, the Sub port SHALL NOT exist and the behaviour SHALL be addition only, as in REQ-017..026.

Verification
REQ-031 A=16'h1234, B=16'h4321, C_in=0, Start pulse -> Done 5 cycles later, Sum=16'h5555, C_out=0; Add_X sequence 4,3,2,1.
REQ-032 A=16'hFFFF, B=16'h0001, C_in=0 -> Sum=16'h0000, C_out=1; Add_Ci sequence 0,1,1,1.
REQ-033 A=16'hA5A5, B=16'h5A5A, C_in=1 -> Sum=16'h0000, C_out=1; Start re-pulsed during RUN with other operands -> ignored, exactly one Done.
REQ-034 Rst_n pulsed low for one cycle during slice 2 of 16'h00FF+16'h0001 -> Busy/Sum/C_out=0 at once, no Done; next Start with 16'h0002+16'h0003 -> Sum=16'h0005.
REQ-035 NIBBLE_ADD_SUB_EN defined, Sub=1, A=16'h0005, B=16'h0007 -> Sum=16'hFFFE, C_out=0; A=16'h0007, B=16'h0005 -> Sum=16'h0002, C_out=1.
REQ-036 Back-to-back operation: Start held high continuously -> a new operation is accepted every NIBBLES+2 cycles, with each Done carrying the correct result.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Purpose: W-bit add (or subtract when NIBBLE_ADD_SUB_EN is defined) one 4-bit slice per cycle through an external 4-bit adder.
// Latency: Done is high for one cycle, NIBBLES+1 edges after the edge that accepts Start; back-to-back period is NIBBLES+2 cycles.
// Backpressure: none; Start is only sampled in IDLE, and a Start seen in RUN or DONE is dropped, not queued.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 C_in,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                 Sub,
`endif
    output logic                 Busy,
    output logic                 Done,
    output logic [4*NIBBLES-1:0] Sum,
    output logic                 C_out,
    output logic [3:0]           Add_X,
    output logic [3:0]           Add_Y,
    output logic                 Add_Ci,
    input  logic [3:0]           Add_S,
    input  logic                 Add_Co
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            c_out_q;
    logic            busy_q;
    logic            done_q;

    // Operand B and carry as they are captured; subtraction is A + ~B + 1.
    logic [W-1:0]    b_capt;
    logic            ci_capt;

`ifdef NIBBLE_ADD_SUB_EN
    assign b_capt  = Sub ? ~B : B;
    assign ci_capt = Sub ? 1'b1 : C_in;
`else
    assign b_capt  = B;
    assign ci_capt = C_in;
`endif

    logic [3:0] slice_x;
    logic [3:0] slice_y;

    // Select slice k of the captured operands for the external adder.
    always_comb begin
        slice_x = 4'h0;
        slice_y = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CW'(i)) begin
                slice_x = a_q[4*i +: 4];
                slice_y = b_q[4*i +: 4];
            end
        end
    end

    // Adder inputs are only live in RUN so the adder sees zeros when idle or reporting.
    assign Add_X  = (state_q == ST_RUN) ? slice_x : 4'h0;
    assign Add_Y  = (state_q == ST_RUN) ? slice_y : 4'h0;
    assign Add_Ci = (state_q == ST_RUN) ? carry_q : 1'b0;

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Sum   = sum_q;
    assign C_out = c_out_q;

    // Control FSM plus datapath registers: capture, per-slice accumulate, one-cycle Done.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        a_q     <= A;
                        b_q     <= b_capt;
                        carry_q <= ci_capt;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        c_out_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt_q == CW'(i)) begin
                            sum_q[4*i +: 4] <= Add_S;
                        end
                    end
                    carry_q <= Add_Co;
                    if (cnt_q == LAST_SLICE) begin
                        cnt_q   <= '0;
                        c_out_q <= Add_Co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Purpose: directed checks of nibble_add_seq with a behavioural 4-bit adder on the slice port.
// Latency: Done expected on the 5th falling edge after the accepting rising edge (NIBBLES=4).
// Backpressure: Start re-pulses during RUN/DONE must be dropped; held Start restarts every 6 cycles.
module tb_nibble_add_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
`ifdef NIBBLE_ADD_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic [3:0]  add_x;
    logic [3:0]  add_y;
    logic        add_ci;
    logic [3:0]  add_s;
    logic        add_co;

    int vectors;
    int miscompares;

    nibble_add_seq #(.NIBBLES(4)) dut (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .Start  (start),
        .A      (a),
        .B      (b),
        .C_in   (c_in),
`ifdef NIBBLE_ADD_SUB_EN
        .Sub    (sub),
`endif
        .Busy   (busy),
        .Done   (done),
        .Sum    (sum),
        .C_out  (c_out),
        .Add_X  (add_x),
        .Add_Y  (add_y),
        .Add_Ci (add_ci),
        .Add_S  (add_s),
        .Add_Co (add_co)
    );

    // External 4-bit adder: purely combinational.
    logic [4:0] adder_full;
    assign adder_full = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_ci};
    assign add_s  = adder_full[3:0];
    assign add_co = adder_full[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive operands with Start at a falling edge and return just after the accepting rising edge.
    task automatic apply_start(input logic [15:0] av, input logic [15:0] bv, input logic ci);
        @(negedge clk);
        a     = av;
        b     = bv;
        c_in  = ci;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Count falling edges after the accepting edge until Done is seen; -1 if it never comes.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        a     = 16'h1234;
        b     = 16'h4321;
        c_in  = 1'b1;
`ifdef NIBBLE_ADD_SUB_EN
        sub   = 1'b0;
`endif
        #1 rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL reset_sum got %h want 0000", sum); end
        vectors++; if (c_out !== 1'b0) begin miscompares++; $display("FAIL reset_cout got %b want 0", c_out); end
        vectors++; if ({add_x, add_y, add_ci} !== 9'h000) begin miscompares++; $display("FAIL reset_add got %h/%h/%b want 0/0/0", add_x, add_y, add_ci); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if ({busy, done, add_x, add_y, add_ci} !== 11'h000) begin miscompares++; $display("FAIL idle_outputs got %b want all 0", {busy, done, add_x, add_y, add_ci}); end
    endtask

    task automatic test_basic();
        logic [3:0] exp_x [4];
        logic [3:0] exp_y [4];
        exp_x = '{4'h4, 4'h3, 4'h2, 4'h1};
        exp_y = '{4'h1, 4'h2, 4'h3, 4'h4};
        apply_start(16'h1234, 16'h4321, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (add_x !== exp_x[k]) begin miscompares++; $display("FAIL basic_add_x[%0d] got %h want %h", k, add_x, exp_x[k]); end
            vectors++; if (add_y !== exp_y[k]) begin miscompares++; $display("FAIL basic_add_y[%0d] got %h want %h", k, add_y, exp_y[k]); end
            vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL basic_run_flags[%0d] got busy/done %b want 10", k, {busy, done}); end
            if (k == 0) begin
                start = 1'b0;
                a     = 16'hFFFF;
                b     = 16'hFFFF;
                c_in  = 1'b1;
            end
        end
        @(negedge clk);
        vectors++; if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL basic_done_flags got busy/done %b want 01", {busy, done}); end
        vectors++; if (sum !== 16'h5555) begin miscompares++; $display("FAIL basic_sum got %h want 5555", sum); end
        vectors++; if (c_out !== 1'b0) begin miscompares++; $display("FAIL basic_cout got %b want 0", c_out); end
        vectors++; if ({add_x, add_y, add_ci} !== 9'h000) begin miscompares++; $display("FAIL basic_done_add got %h/%h/%b want 0/0/0", add_x, add_y, add_ci); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
        vectors++; if (sum !== 16'h5555) begin miscompares++; $display("FAIL basic_sum_hold got %h want 5555", sum); end
    endtask

    task automatic test_carry_chain();
        logic exp_ci [4];
        exp_ci = '{1'b0, 1'b1, 1'b1, 1'b1};
        apply_start(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (add_ci !== exp_ci[k]) begin miscompares++; $display("FAIL carry_add_ci[%0d] got %b want %b", k, add_ci, exp_ci[k]); end
            if (k == 0) start = 1'b0;
        end
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL carry_done got %b want 1", done); end
        vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL carry_sum got %h want 0000", sum); end
        vectors++; if (c_out !== 1'b1) begin miscompares++; $display("FAIL carry_cout got %b want 1", c_out); end
    endtask

    task automatic test_ignore_start();
        int          done_cnt;
        int          done_at;
        logic [15:0] got_sum;
        logic        got_co;
        logic        busy_late;
        done_cnt  = 0;
        done_at   = -1;
        got_sum   = 16'hDEAD;
        got_co    = 1'b0;
        busy_late = 1'b0;
        apply_start(16'hA5A5, 16'h5A5A, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
                got_sum = sum;
                got_co  = c_out;
            end
            if (i >= 7 && busy !== 1'b0) busy_late = 1'b1;
            if (i == 2) begin
                start = 1'b1;
                a     = 16'h1111;
                b     = 16'h1111;
                c_in  = 1'b0;
            end
            if (i == 6) start = 1'b0;
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
        vectors++; if (done_at != 5) begin miscompares++; $display("FAIL ignore_done_edge got %0d want 5", done_at); end
        vectors++; if (got_sum !== 16'h0000) begin miscompares++; $display("FAIL ignore_sum got %h want 0000", got_sum); end
        vectors++; if (got_co !== 1'b1) begin miscompares++; $display("FAIL ignore_cout got %b want 1", got_co); end
        vectors++; if (busy_late !== 1'b0) begin miscompares++; $display("FAIL ignore_not_queued got busy %b want 0", busy_late); end
    endtask

    task automatic test_reset_abort();
        int   n;
        logic saw_done;
        saw_done = 1'b0;
        apply_start(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if ({busy, add_ci} !== 2'b11) begin miscompares++; $display("FAIL abort_slice2 got busy/add_ci %b want 11", {busy, add_ci}); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({busy, done, c_out, add_ci} !== 4'b0000) begin miscompares++; $display("FAIL abort_flags got %b want 0000", {busy, done, c_out, add_ci}); end
        vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL abort_sum got %h want 0000", sum); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got %b want 0", saw_done); end
        apply_start(16'h0002, 16'h0003, 1'b0);
        wait_done(n);
        vectors++; if (n != 5) begin miscompares++; $display("FAIL abort_restart_latency got %0d want 5", n); end
        vectors++; if (sum !== 16'h0005) begin miscompares++; $display("FAIL abort_restart_sum got %h want 0005", sum); end
    endtask

`ifdef NIBBLE_ADD_SUB_EN
    task automatic test_subtract();
        int n;
        sub = 1'b1;
        apply_start(16'h0005, 16'h0007, 1'b0);
        wait_done(n);
        vectors++; if (n != 5) begin miscompares++; $display("FAIL sub1_latency got %0d want 5", n); end
        vectors++; if ({c_out, sum} !== {1'b0, 16'hFFFE}) begin miscompares++; $display("FAIL sub1_result got %b/%h want 0/FFFE", c_out, sum); end
        apply_start(16'h0007, 16'h0005, 1'b0);
        wait_done(n);
        vectors++; if ({c_out, sum} !== {1'b1, 16'h0002}) begin miscompares++; $display("FAIL sub2_result got %b/%h want 1/0002", c_out, sum); end
        sub = 1'b0;
        apply_start(16'h0007, 16'h0005, 1'b1);
        wait_done(n);
        vectors++; if ({c_out, sum} !== {1'b0, 16'h000D}) begin miscompares++; $display("FAIL sub_off_add got %b/%h want 0/000D", c_out, sum); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [15:0] op_a   [3];
        logic [15:0] op_b   [3];
        logic        op_ci  [3];
        logic [15:0] exp_s  [3];
        logic        exp_co [3];
        int          idx;
        op_a   = '{16'h1111, 16'h8000, 16'h0FFF};
        op_b   = '{16'h2222, 16'h8000, 16'h0001};
        op_ci  = '{1'b0, 1'b0, 1'b1};
        exp_s  = '{16'h3333, 16'h0000, 16'h1001};
        exp_co = '{1'b0, 1'b1, 1'b0};
        idx = 0;
        @(negedge clk);
        a     = op_a[0];
        b     = op_b[0];
        c_in  = op_ci[0];
        start = 1'b1;
        for (int i = 1; i <= 40 && idx < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                vectors++; if (i != 5 + 6 * idx) begin miscompares++; $display("FAIL b2b_done_edge[%0d] got %0d want %0d", idx, i, 5 + 6 * idx); end
                vectors++; if ({c_out, sum} !== {exp_co[idx], exp_s[idx]}) begin miscompares++; $display("FAIL b2b_result[%0d] got %b/%h want %b/%h", idx, c_out, sum, exp_co[idx], exp_s[idx]); end
                idx++;
                if (idx < 3) begin
                    a    = op_a[idx];
                    b    = op_b[idx];
                    c_in = op_ci[idx];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        vectors++; if (idx != 3) begin miscompares++; $display("FAIL b2b_done_count got %0d want 3", idx); end
        @(negedge clk);
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_stop got busy %b want 0", busy); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_ignore_start();
        test_reset_abort();
`ifdef NIBBLE_ADD_SUB_EN
        test_subtract();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
